// File: rtl/dcache_victim_ctrl_pkg.sv
// Shared data-cache definitions: geometry constants and the victim-controller state encoding.
package cache_defs;

    localparam int unsigned DCACHE_LINE_WIDTH = 64;
    localparam int unsigned DCACHE_TAG_BITS   = 20;
    localparam int unsigned VICTIM_NO_OF_SETS = 8;

    typedef enum logic [2:0] {
        VC_IDLE,
        VC_PROBE,
        VC_SWAP,
        VC_MEM_REQ,
        VC_INSERT,
        VC_RESP
    } vc_ctrl_state_e;

endpackage

// File: rtl/dcache_victim_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dcache_victim_ctrl.sv
// Dcache miss-side controller: probes the victim cache, swaps on hit or refills from
// memory on miss, always pushes the evicted line into the victim cache, keeps hit/miss stats.
module dcache_victim_ctrl #(
    parameter int unsigned DCACHE_LINE_WIDTH = cache_defs::DCACHE_LINE_WIDTH,
    parameter int unsigned DCACHE_TAG_BITS   = cache_defs::DCACHE_TAG_BITS,
    parameter int unsigned STAT_WIDTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req_i,
    input  logic [DCACHE_TAG_BITS-1:0]   miss_tag_i,
    input  logic                         evict_valid_i,
    input  logic [DCACHE_TAG_BITS-1:0]   evict_tag_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         busy_o,
    output logic                         refill_valid_o,
    output logic [DCACHE_TAG_BITS-1:0]   refill_tag_o,
    output logic [DCACHE_LINE_WIDTH-1:0] refill_data_o,
    output logic                         refill_from_victim_o,
    output logic [DCACHE_TAG_BITS-1:0]   victim_lookup_tag_o,
    input  logic                         victim_hit_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] victim_data_i,
    output logic                         victim_inval_o,
    output logic                         victim_write_o,
    output logic [DCACHE_TAG_BITS-1:0]   victim_wtag_o,
    output logic [DCACHE_LINE_WIDTH-1:0] victim_wdata_o,
    output logic                         mem_req_o,
    output logic [DCACHE_TAG_BITS-1:0]   mem_tag_o,
    input  logic                         mem_ack_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] mem_data_i,
    output logic [STAT_WIDTH-1:0]        hit_count_o,
    output logic [STAT_WIDTH-1:0]        miss_count_o
);

    import cache_defs::*;

    vc_ctrl_state_e               state_q;
    logic [DCACHE_TAG_BITS-1:0]   tag_q;
    logic                         evalid_q;
    logic [DCACHE_TAG_BITS-1:0]   etag_q;
    logic [DCACHE_LINE_WIDTH-1:0] edata_q;
    logic [DCACHE_LINE_WIDTH-1:0] buf_q;
    logic                         from_victim_q;

    logic                         busy_q;
    logic                         refill_valid_q;
    logic                         refill_fv_q;
    logic                         inval_q;
    logic                         write_q;
    logic                         mem_req_q;

    logic                         hit_inc;
    logic                         miss_inc;

    assign hit_inc  = (state_q == VC_PROBE) &&  victim_hit_i;
    assign miss_inc = (state_q == VC_PROBE) && !victim_hit_i;

    // Strobes are registered on entry to the state that owns them, so each is high
    // exactly while that state is current and drops asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= VC_IDLE;
            tag_q          <= '0;
            evalid_q       <= 1'b0;
            etag_q         <= '0;
            edata_q        <= '0;
            buf_q          <= '0;
            from_victim_q  <= 1'b0;
            busy_q         <= 1'b0;
            refill_valid_q <= 1'b0;
            refill_fv_q    <= 1'b0;
            inval_q        <= 1'b0;
            write_q        <= 1'b0;
            mem_req_q      <= 1'b0;
        end else begin
            inval_q        <= 1'b0;
            write_q        <= 1'b0;
            refill_valid_q <= 1'b0;
            refill_fv_q    <= 1'b0;
            unique case (state_q)
                VC_IDLE: begin
                    if (miss_req_i) begin
                        tag_q    <= miss_tag_i;
                        evalid_q <= evict_valid_i;
                        etag_q   <= evict_tag_i;
                        edata_q  <= evict_data_i;
                        busy_q   <= 1'b1;
                        state_q  <= VC_PROBE;
                    end
                end
                VC_PROBE: begin
                    if (victim_hit_i) begin
                        buf_q         <= victim_data_i;
                        from_victim_q <= 1'b1;
                        inval_q       <= 1'b1;
                        state_q       <= VC_SWAP;
                    end else begin
                        from_victim_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        state_q       <= VC_MEM_REQ;
                    end
                end
                VC_SWAP: begin
                    write_q <= evalid_q;
                    state_q <= VC_INSERT;
                end
                VC_MEM_REQ: begin
                    if (mem_ack_i) begin
                        buf_q     <= mem_data_i;
                        mem_req_q <= 1'b0;
                        write_q   <= evalid_q;
                        state_q   <= VC_INSERT;
                    end
                end
                VC_INSERT: begin
                    refill_valid_q <= 1'b1;
                    refill_fv_q    <= from_victim_q;
                    state_q        <= VC_RESP;
                end
                VC_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= VC_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= VC_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count_o)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count_o)
    );

    assign busy_o               = busy_q;
    assign refill_valid_o       = refill_valid_q;
    assign refill_tag_o         = tag_q;
    assign refill_data_o        = buf_q;
    assign refill_from_victim_o = refill_fv_q;
    assign victim_lookup_tag_o  = tag_q;
    assign victim_inval_o       = inval_q;
    assign victim_write_o       = write_q;
    assign victim_wtag_o        = etag_q;
    assign victim_wdata_o       = edata_q;
    assign mem_req_o            = mem_req_q;
    assign mem_tag_o            = tag_q;

endmodule
